imm_gen_pipe: RTL and testbench

- Registered, parametrised immediate generator sitting between ID and EX.
- Decodes all RV32I immediate formats (I, shamt, S, B, U, J) from a fetched instruction and sign-extends to XLEN.
- Outputs go through a 2-entry elastic buffer with valid/ready handshakes on both sides and a pipeline flush input.
- Carries a sideband tag (e.g. PC or ROB index) alongside each immediate.

---
 rtl/imm_pkg.sv | 27 ++
 rtl/imm_gen_pipe_if.sv | 29 ++
 rtl/imm_decode.sv | 67 ++++++
 rtl/imm_gen_pipe.sv | 89 ++++++++
 tb/tb_imm_gen_pipe.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the RV32I immediate generator: opcodes, shift funct3 codes
// and the format encoding reported alongside each immediate.
package imm_pkg;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;

   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRXI = 3'b101;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_SHAMT = 3'd2,
      FMT_S     = 3'd3,
      FMT_B     = 3'd4,
      FMT_U     = 3'd5,
      FMT_J     = 3'd6
   } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate generator: instruction push side, immediate pop
// side and the pipeline flush. The DUT takes the slave view.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);

   logic             flush_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [31:0]      instr_i;
   logic [TAG_W-1:0] tag_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [XLEN-1:0]  imm_o;
   logic [2:0]       fmt_o;
   logic [TAG_W-1:0] tag_o;

   modport master (
      output flush_i, in_valid_i, instr_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, imm_o, fmt_o, tag_o
   );

   modport slave (
      input  flush_i, in_valid_i, instr_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, imm_o, fmt_o, tag_o
   );

endinterface

// File: rtl/imm_decode.sv
// Purely combinational RV32I immediate decoder: instruction word in, sign-extended
// immediate and its format out. Also usable directly by a single-cycle datapath.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit HALFWORD_BR = 1'b1
) (
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] imm_o,
   output fmt_e            fmt_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];

   // Signed casts widen to XLEN by replicating the immediate's top bit.
   always_comb begin
      imm_o = '0;
      fmt_o = FMT_NONE;
      case (opcode)
         OP_IMM: begin
            if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
               fmt_o = FMT_SHAMT;
               imm_o = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
            end else begin
               fmt_o = FMT_I;
               imm_o = XLEN'($signed(instr_i[31:20]));
            end
         end
         LOAD, JALR: begin
            fmt_o = FMT_I;
            imm_o = XLEN'($signed(instr_i[31:20]));
         end
         STORE: begin
            fmt_o = FMT_S;
            imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
         end
         BRANCH: begin
            fmt_o = FMT_B;
            if (HALFWORD_BR)
               imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]}));
            else
               imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
         end
         LUI, AUIPC: begin
            fmt_o = FMT_U;
            imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
         end
         JAL: begin
            fmt_o = FMT_J;
            if (HALFWORD_BR)
               imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]}));
            else
               imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
         end
         default: begin
            imm_o = '0;
            fmt_o = FMT_NONE;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// ID->EX immediate generator: decodes the presented instruction and queues the
// immediate, format and tag in a 2-entry elastic FIFO with flush.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int TAG_W       = 8,
   parameter bit HALFWORD_BR = 1'b1
) (
   input logic          clk_i,
   input logic          rst_i,
   imm_gen_pipe_if.slave bus
);

   logic [XLEN-1:0]  immDec;
   fmt_e             fmtDec;

   logic [XLEN-1:0]  immMem_q [2];
   fmt_e             fmtMem_q [2];
   logic [TAG_W-1:0] tagMem_q [2];

   logic       rdPtr_q, rdPtr_d;
   logic       wrPtr_q, wrPtr_d;
   logic [1:0] count_q, count_d;

   logic inReady, outValid, push, pop;

   imm_decode #(
      .XLEN       (XLEN),
      .HALFWORD_BR(HALFWORD_BR)
   ) uDecode (
      .instr_i(bus.instr_i),
      .imm_o  (immDec),
      .fmt_o  (fmtDec)
   );

   // Handshake flags come only from registered count, so in_ready never sees out_ready.
   assign inReady  = (count_q != 2'd2);
   assign outValid = (count_q != 2'd0);
   assign push     = bus.in_valid_i && inReady;
   assign pop      = outValid && bus.out_ready_i;

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (bus.flush_i) begin
         rdPtr_d = 1'b0;
         wrPtr_d = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push) wrPtr_d = ~wrPtr_q;
         if (pop)  rdPtr_d = ~rdPtr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         rdPtr_q <= 1'b0;
         wrPtr_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: stale slots are hidden by the output mask below.
   always_ff @(posedge clk_i) begin
      if (push && !bus.flush_i) begin
         immMem_q[wrPtr_q] <= immDec;
         fmtMem_q[wrPtr_q] <= fmtDec;
         tagMem_q[wrPtr_q] <= bus.tag_i;
      end
   end

   assign bus.in_ready_o  = inReady;
   assign bus.out_valid_o = outValid;
   assign bus.imm_o       = outValid ? immMem_q[rdPtr_q] : '0;
   assign bus.fmt_o       = outValid ? fmtMem_q[rdPtr_q] : FMT_NONE;
   assign bus.tag_o       = outValid ? tagMem_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed instructions with hand-decoded immediates,
// backpressure, flush and mid-stream reset; a negedge monitor checks every popped entry.
module tb_imm_gen_pipe;
   import imm_pkg::*;

   localparam int XLEN  = 32;
   localparam int TAG_W = 8;
   localparam bit HB    = 1'b1;

   localparam logic [31:0] ADDI_M1  = 32'hFFF00093;
   localparam logic [31:0] SRAI_3   = 32'h4030D093;
   localparam logic [31:0] LUI_X    = 32'h123450B7;
   localparam logic [31:0] SW_M4    = 32'hFE20AE23;
   localparam logic [31:0] BEQ_M8   = 32'hFE000CE3;
   localparam logic [31:0] JAL_800  = 32'h001000EF;
   localparam logic [31:0] LW_7FF   = 32'h7FF12083;
   localparam logic [31:0] AUIPC_HI = 32'h80000097;
   localparam logic [31:0] ADD_R    = 32'h003100B3;

   localparam logic [31:0] BEQ_EXP = HB ? 32'hFFFFFFFC : 32'hFFFFFFF8;
   localparam logic [31:0] JAL_EXP = HB ? 32'h00000400 : 32'h00000800;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
      logic [TAG_W-1:0] tag;
   } expEntry_t;

   logic      clk = 1'b0;
   logic      rstN;
   expEntry_t expQ[$];
   expEntry_t monEntry;
   int        assertCount = 0;
   int        failCount   = 0;
   time       t0;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   imm_gen_pipe #(
      .XLEN       (XLEN),
      .TAG_W      (TAG_W),
      .HALFWORD_BR(HB)
   ) dut (
      .clk_i(clk),
      .rst_i(rstN),
      .bus  (bus.slave)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Offers one instruction and records its expected result once the DUT takes it.
   task automatic applyStimulus(input logic [31:0] instr, input logic [TAG_W-1:0] tag,
                                input logic [XLEN-1:0] expImm, input logic [2:0] expFmt);
      bit taken = 1'b0;
      bus.in_valid_i = 1'b1;
      bus.instr_i    = instr;
      bus.tag_i      = tag;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.in_ready_o) begin
            taken = 1'b1;
            break;
         end
      end
      if (taken) begin
         expQ.push_back('{imm: expImm, fmt: expFmt, tag: tag});
      end else begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL pushTimeout: in_ready_o stayed 0, expected 1 for tag 0x%0h", tag);
         bus.in_valid_i = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      bus.in_valid_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drainQueue(input string name);
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      for (int n = 0; n < 50 && expQ.size() != 0; n++) @(posedge clk);
      #1;
      checkOutput(name, 64'(expQ.size()), 64'd0);
   endtask

   // Compares every accepted head entry; an empty buffer must present zeros.
   always @(negedge clk) begin
      if (rstN && !bus.flush_i) begin
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (expQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL unexpectedOutput: got tag 0x%0h imm 0x%0h, expected no output",
                        bus.tag_o, bus.imm_o);
            end else begin
               monEntry = expQ.pop_front();
               checkOutput($sformatf("imm(tag 0x%0h)", monEntry.tag), 64'(bus.imm_o), 64'(monEntry.imm));
               checkOutput($sformatf("fmt(tag 0x%0h)", monEntry.tag), 64'(bus.fmt_o), 64'(monEntry.fmt));
               checkOutput("tagOrder", 64'(bus.tag_o), 64'(monEntry.tag));
            end
         end else if (!bus.out_valid_o) begin
            checkOutput("maskImm", 64'(bus.imm_o), 64'd0);
            checkOutput("maskFmt", 64'(bus.fmt_o), 64'd0);
            checkOutput("maskTag", 64'(bus.tag_o), 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN            = 1'b0;
      bus.flush_i     = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.instr_i     = '0;
      bus.tag_i       = '0;
      bus.out_ready_i = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstValid", 64'(bus.out_valid_o), 64'd0);
      checkOutput("rstReady", 64'(bus.in_ready_o), 64'd1);
      checkOutput("rstImm", 64'(bus.imm_o), 64'd0);
      checkOutput("rstFmt", 64'(bus.fmt_o), 64'd0);
      checkOutput("rstTag", 64'(bus.tag_o), 64'd0);
      @(posedge clk);
      #1;
      rstN            = 1'b1;
      bus.out_ready_i = 1'b1;

      applyStimulus(ADDI_M1, 8'hA1, 32'hFFFFFFFF, FMT_I);
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      checkOutput("latencyValid", 64'(bus.out_valid_o), 64'd1);
      @(posedge clk);
      #1;

      t0 = $time;
      applyStimulus(SRAI_3,   8'hA2, 32'h00000003, FMT_SHAMT);
      applyStimulus(LUI_X,    8'hA3, 32'h12345000, FMT_U);
      applyStimulus(SW_M4,    8'hA4, 32'hFFFFFFFC, FMT_S);
      applyStimulus(BEQ_M8,   8'hA5, BEQ_EXP,      FMT_B);
      applyStimulus(JAL_800,  8'hA6, JAL_EXP,      FMT_J);
      applyStimulus(LW_7FF,   8'hA7, 32'h000007FF, FMT_I);
      applyStimulus(AUIPC_HI, 8'hA8, 32'h80000000, FMT_U);
      applyStimulus(ADD_R,    8'hA9, 32'h00000000, FMT_NONE);
      checkOutput("throughput", 64'($time - t0), 64'd80);
      idleCycle();
      drainQueue("drainStream");

      bus.out_ready_i = 1'b0;
      applyStimulus(ADDI_M1, 8'h01, 32'hFFFFFFFF, FMT_I);
      applyStimulus(LUI_X,   8'h02, 32'h12345000, FMT_U);
      bus.in_valid_i = 1'b1;
      bus.instr_i    = SRAI_3;
      bus.tag_i      = 8'h03;
      repeat (3) begin
         @(negedge clk);
         checkOutput("fullInReady", 64'(bus.in_ready_o), 64'd0);
         checkOutput("fullOutValid", 64'(bus.out_valid_o), 64'd1);
      end
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b1;
      applyStimulus(SRAI_3, 8'h03, 32'h00000003, FMT_SHAMT);
      idleCycle();
      drainQueue("drainBackpressure");
      @(negedge clk);
      checkOutput("readyRecovered", 64'(bus.in_ready_o), 64'd1);
      @(posedge clk);
      #1;

      bus.out_ready_i = 1'b0;
      applyStimulus(LUI_X, 8'h10, 32'h12345000, FMT_U);
      bus.flush_i    = 1'b1;
      bus.in_valid_i = 1'b1;
      bus.instr_i    = ADDI_M1;
      bus.tag_i      = 8'h11;
      @(negedge clk);
      expQ.delete();
      @(posedge clk);
      #1;
      bus.flush_i    = 1'b0;
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      checkOutput("flushValid", 64'(bus.out_valid_o), 64'd0);
      checkOutput("flushReady", 64'(bus.in_ready_o), 64'd1);
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      bus.out_ready_i = 1'b0;
      applyStimulus(SW_M4,  8'h20, 32'hFFFFFFFC, FMT_S);
      applyStimulus(BEQ_M8, 8'h21, BEQ_EXP,      FMT_B);
      bus.in_valid_i = 1'b0;
      @(negedge clk);
      checkOutput("preRstFull", 64'(bus.in_ready_o), 64'd0);
      @(posedge clk);
      #1;
      rstN = 1'b0;
      @(negedge clk);
      expQ.delete();
      @(posedge clk);
      #1;
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("midRstValid", 64'(bus.out_valid_o), 64'd0);
      checkOutput("midRstReady", 64'(bus.in_ready_o), 64'd1);
      checkOutput("midRstImm", 64'(bus.imm_o), 64'd0);
      checkOutput("midRstFmt", 64'(bus.fmt_o), 64'd0);
      checkOutput("midRstTag", 64'(bus.tag_o), 64'd0);
      @(posedge clk);
      #1;

      bus.out_ready_i = 1'b1;
      applyStimulus(ADD_R,  8'h30, 32'h00000000, FMT_NONE);
      applyStimulus(LW_7FF, 8'h31, 32'h000007FF, FMT_I);
      idleCycle();
      drainQueue("drainFinal");

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
